// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU front-end sequencer:
//   - ALU_WIDTH   : default operand/result width
//   - ALU_*       : 4-bit ALU opcode encoding
//   - seq_state_e : sequencer state encoding
//   - op_is_div() : true for the two divider opcodes (DIV, MOD)
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [3:0] ALU_OR  = 4'h0;
   localparam logic [3:0] ALU_XOR = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_ADD = 4'h4;
   localparam logic [3:0] ALU_SUB = 4'h5;
   localparam logic [3:0] ALU_MUL = 4'h6;
   localparam logic [3:0] ALU_SHL = 4'h8;
   localparam logic [3:0] ALU_SAR = 4'h9;
   localparam logic [3:0] ALU_DIV = 4'hA;
   localparam logic [3:0] ALU_MOD = 4'hB;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EXEC = 3'd1,
      ST_MUL  = 3'd2,
      ST_DIV  = 3'd3,
      ST_FIX  = 3'd4,
      ST_DONE = 3'd5
   } seq_state_e;

   function automatic logic op_is_div(input logic [3:0] op);
      return (op == ALU_DIV) || (op == ALU_MOD);
   endfunction

endpackage : alu_pkg

// File: rtl/alu_iter_divider.sv
// -----------------------------------------------------------------------------
// alu_iter_divider
// Restoring unsigned divider, one quotient bit per clock. Works on operand
// magnitudes; the caller applies signs afterwards.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   start_i          load dividend/divisor and begin (one-cycle pulse)
//   dividend_i       unsigned dividend
//   divisor_i        unsigned divisor (caller guarantees non-zero)
//   done_o           high once WIDTH steps have completed, until next start
//   quotient_o       unsigned quotient  (valid while done_o)
//   remainder_o      unsigned remainder (valid while done_o)
// Timing: start sampled at edge k, steps at edges k+1..k+WIDTH, done_o high
// from edge k+WIDTH onward.
// -----------------------------------------------------------------------------
module alu_iter_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
)
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] STEPS = CW'(WIDTH);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             run_q;

   logic [WIDTH:0]   rem_shift_s;
   logic [WIDTH:0]   diff_s;
   logic             fits_s;

   // Trial subtraction: partial remainder shifted left with next dividend bit
   // (dividend bits are shifted out of the top of quo_q as quotient bits enter).
   always_comb begin
      rem_shift_s = {rem_q, quo_q[WIDTH-1]};
      diff_s      = rem_shift_s - {1'b0, dvs_q};
      fits_s      = ~diff_s[WIDTH];
   end

   // Divider iteration registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q && (cnt_q != STEPS)) begin
         if (fits_s) begin
            rem_q <= diff_s[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= rem_shift_s[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt_q <= cnt_q + CW'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign done_o      = run_q && (cnt_q == STEPS);
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule : alu_iter_divider

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Front-end controller for the integer ALU. Takes one operation per
// valid/ready request, runs single-cycle ops through the combinational ALU,
// sequences MUL (shift-add) and DIV/MOD (iterative divider + sign fix-up),
// and holds the result until the consumer takes it.
// Configuration: define ALU_SEQ_DIV_EN to build the divider. Without it,
// DIV/MOD opcodes are reported as illegal (data 0, err 1, latency 1).
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   req_valid_i      request present
//   req_ready_o      sequencer idle and able to accept
//   req_op_i         ALU opcode
//   req_d0_i         left operand
//   req_d1_i         right operand
//   rsp_valid_o      result present (held until rsp_ready_i)
//   rsp_ready_i      consumer takes result
//   rsp_data_o       d0 op d1
//   rsp_err_o        illegal opcode or divide by zero
//   busy_o           sequencer not idle
// Latency accept->rsp_valid: EXEC 1, MUL WIDTH+1, DIV/MOD WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
)
(
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [3:0]       req_op_i,
   input  logic [WIDTH-1:0] req_d0_i,
   input  logic [WIDTH-1:0] req_d1_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic             rsp_err_o,
   output logic             busy_o
);

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH);

   seq_state_e       state_q;
   seq_state_e       state_d;

   logic [3:0]       op_q;
   logic [WIDTH-1:0] d0_q;
   logic [WIDTH-1:0] d1_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic             rsp_err_q;

   logic             accept_s;
   logic             div_go_s;
   logic             div_done_s;
   logic [WIDTH-1:0] fix_res_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_err_s;

   assign accept_s = req_valid_i && (state_q == ST_IDLE);

`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH-1:0] div_a_s;
   logic [WIDTH-1:0] div_b_s;
   logic [WIDTH-1:0] div_quo_s;
   logic [WIDTH-1:0] div_rem_s;
   logic [WIDTH-1:0] quo_signed_s;
   logic [WIDTH-1:0] rem_signed_s;

   // A zero divisor never reaches the divider; it is reported from EXEC.
   assign div_go_s = accept_s && op_is_div(req_op_i) && (req_d1_i != '0);

   // Divider runs on magnitudes taken straight from the request operands
   always_comb begin
      div_a_s = req_d0_i[WIDTH-1] ? (~req_d0_i + WIDTH'(1)) : req_d0_i;
      div_b_s = req_d1_i[WIDTH-1] ? (~req_d1_i + WIDTH'(1)) : req_d1_i;
   end

   alu_iter_divider #(
      .WIDTH       (WIDTH)
   ) u_div (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .start_i     (div_go_s),
      .dividend_i  (div_a_s),
      .divisor_i   (div_b_s),
      .done_o      (div_done_s),
      .quotient_o  (div_quo_s),
      .remainder_o (div_rem_s)
   );

   // Sign fix-up: quotient negative when operand signs differ, remainder
   // follows the dividend. INT_MIN/-1 falls out naturally as INT_MIN.
   always_comb begin
      quo_signed_s = (d0_q[WIDTH-1] ^ d1_q[WIDTH-1]) ? (~div_quo_s + WIDTH'(1)) : div_quo_s;
      rem_signed_s = d0_q[WIDTH-1] ? (~div_rem_s + WIDTH'(1)) : div_rem_s;
      if (op_q == ALU_DIV) begin
         fix_res_s = quo_signed_s;
      end else begin
         fix_res_s = rem_signed_s;
      end
   end
`else
   assign div_go_s   = 1'b0;
   assign div_done_s = 1'b0;
   assign fix_res_s  = '0;
`endif

   // Combinational ALU for single-cycle ops; anything else reaching EXEC is
   // an error (illegal opcode, divide by zero, or divider not built).
   always_comb begin
      alu_res_s = '0;
      alu_err_s = 1'b0;
      case (op_q)
         ALU_OR:  alu_res_s = d0_q | d1_q;
         ALU_XOR: alu_res_s = d0_q ^ d1_q;
         ALU_AND: alu_res_s = d0_q & d1_q;
         ALU_ADD: alu_res_s = d0_q + d1_q;
         ALU_SUB: alu_res_s = d0_q - d1_q;
         ALU_SHL: alu_res_s = d0_q << d1_q[SHW-1:0];
         ALU_SAR: alu_res_s = WIDTH'($signed(d0_q) >>> d1_q[SHW-1:0]);
         default: begin
            alu_res_s = '0;
            alu_err_s = 1'b1;
         end
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (req_op_i == ALU_MUL) begin
                  state_d = ST_MUL;
               end else if (div_go_s) begin
                  state_d = ST_DIV;
               end else begin
                  state_d = ST_EXEC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: state_d = ST_DONE;
         ST_MUL: begin
            if (cnt_q == MUL_STEPS) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DIV: begin
            if (div_done_s) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_DIV;
            end
         end
         ST_FIX: state_d = ST_DONE;
         ST_DONE: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture, shift-add multiplier and response registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         op_q       <= 4'h0;
         d0_q       <= '0;
         d1_q       <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  op_q     <= req_op_i;
                  d0_q     <= req_d0_i;
                  d1_q     <= req_d1_i;
                  acc_q    <= '0;
                  mcand_q  <= req_d0_i;
                  mplier_q <= req_d1_i;
                  cnt_q    <= '0;
               end
            end
            ST_EXEC: begin
               rsp_data_q <= alu_res_s;
               rsp_err_q  <= alu_err_s;
            end
            ST_MUL: begin
               // WIDTH add/shift steps, then one cycle to publish the product
               if (cnt_q != MUL_STEPS) begin
                  if (mplier_q[0]) begin
                     acc_q <= acc_q + mcand_q;
                  end
                  mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
                  mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                  cnt_q    <= cnt_q + CW'(1);
               end else begin
                  rsp_data_q <= acc_q;
                  rsp_err_q  <= 1'b0;
               end
            end
            ST_FIX: begin
               rsp_data_q <= fix_res_s;
               rsp_err_q  <= 1'b0;
            end
            default: begin
               rsp_data_q <= rsp_data_q;
            end
         endcase
      end
   end

   assign req_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign rsp_valid_o = (state_q == ST_DONE);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_err_o   = rsp_err_q;

endmodule : alu_op_sequencer
